feed_arbiter: RTL
=================

# feed_arbiter

Shares one `market_parser` byte port between `NUM_FEEDS` independent market-data byte sources. Grants are message-granular: once a feed is granted, the block forwards its bytes until the message ends and the parser signals completion. Grants rotate round-robin. The block sits between the feed sources and `parser_top`: it drives the parser's byte/valid inputs and consumes its ready/done outputs.

## Interface
- `NUM_FEEDS`, 4: number of requesting feeds, 2..8.
- `DATA_WIDTH`, 7: MSB index of a feed byte; bytes are `[DATA_WIDTH:0]`.
- `TIMEOUT_CYCLES`, 1023: idle cycles tolerated mid-message; used only with `FEED_TIMEOUT_EN`.

Ports:
- `clk_in` in 1: sole clock.
- `reset_in` in 1: synchronous, active-high reset.
- `feed_data_in` in `NUM_FEEDS*(DATA_WIDTH+1)`: feed i byte at `[i*(DATA_WIDTH+1) +: DATA_WIDTH+1]`.
- `feed_valid_in` in `NUM_FEEDS`: per-feed byte valid.
- `feed_last_in` in `NUM_FEEDS`: byte is the final byte of its message.
- `feed_ready_out` out `NUM_FEEDS`: per-feed byte accepted.
- `parser_data_out` out `DATA_WIDTH+1`: byte to parser.
- `parser_valid_out` out 1: byte valid to parser.
- `parser_ready_in` in 1: parser accepts a byte this cycle.
- `parser_done_in` in 1: parser finished decoding the message.
- `grant_out` out `NUM_FEEDS`: one-hot current owner; 0 when idle.
- `grant_id_out` out `$clog2(NUM_FEEDS)`: index of the current or last owner.
- `busy_out` out 1: state is not IDLE.
- `msg_count_out` out 16: completed messages, wraps at 0xFFFF→0.
- `abort_out` out 1: one-cycle pulse on timeout abort.
- `parser_reset_out` out 1: one-cycle pulse, ORed by the integrator into the parser reset.

## Operation
- States:
  - IDLE
  - STREAM
  - WAIT_DONE
  - ABORT and FLUSH, present only with the macro.
- Reset: state IDLE, round-robin pointer 0, all outputs 0.
- IDLE: if any `feed_valid_in` is high, pick the first valid feed at or after the RR pointer, with wrap-around. Register it into `grant_out`/`grant_id_out` and go to STREAM. With no requests, stay in IDLE.
- STREAM: pure combinational pass-through for the granted feed g:
  - `parser_data_out` = byte g.
  - `parser_valid_out` = `feed_valid_in[g]`.
  - `feed_ready_out[g]` = `parser_ready_in`.
  - All other ready bits are 0.
  - A transfer is valid & ready. A transfer with `feed_last_in[g]` moves to WAIT_DONE.
- WAIT_DONE: all readies 0, `parser_valid_out` 0. On `parser_done_in`:
  - Increment `msg_count_out`.
  - Set RR pointer = g+1 mod `NUM_FEEDS`.
  - Clear `grant_out`, go to IDLE.
- `parser_done_in` in the same cycle as the last-byte transfer completes the message directly (STREAM→IDLE).
- `parser_done_in` outside STREAM/WAIT_DONE, or in STREAM without a last transfer, is ignored.
- Requests arriving while busy wait; no preemption.
- `reset_in` mid-message drops the grant immediately; no partial-message recovery.

## Timing
- Arbitration latency: 1 cycle. A request in IDLE at cycle n gives `grant_out` valid and the first possible transfer at n+1.
- Byte path: zero-latency combinational from feed to parser. Throughput is 1 byte/cycle while both sides are ready.
- Re-arbitration: the first IDLE cycle after done, so one dead cycle between messages.
- `abort_out`/`parser_reset_out`: high exactly one cycle, registered.

## Configuration
- Macro `FEED_TIMEOUT_EN`. When defined:
  - A counter clears on every transfer and on entering STREAM, and increments in STREAM/WAIT_DONE.
  - Reaching `TIMEOUT_CYCLES` enters ABORT for 1 cycle: pulse `abort_out` and `parser_reset_out`, advance RR pointer past g.
  - ABORT goes to FLUSH. In FLUSH: `feed_ready_out[g]`=1, `parser_valid_out`=0, bytes are discarded until a last transfer, then IDLE.
  - FLUSH also times out to IDLE, with no second abort pulse.
  - `msg_count_out` is not incremented for aborted messages.
- When undefined: no counter, no ABORT/FLUSH states; `abort_out` and `parser_reset_out` tied to 0.

## Structure
- `parser_pkg`: `feed_arb_state_t` enum and the msg-count width constant (16).
- Sub-module `rr_arbiter`: combinational. Inputs are the request vector and pointer; outputs are the one-hot grant and index.

## Test plan
- Single feed 1, 3-byte message 0x41,0x42,0x43, with `parser_ready_in`=1 and done on the cycle after the last byte:
  - grant_out=0010 one cycle after valid.
  - Bytes reach the parser in order.
  - msg_count 0→1.
  - busy_out low 1 cycle after done.
- All 4 feeds requesting continuously, 2-byte messages → grant order 0,1,2,3,0 and no byte interleaving.
- Parser backpressure: `parser_ready_in` toggling 1010 → `feed_ready_out[g]` mirrors it; no byte dropped or duplicated.
- Done coincident with last byte → IDLE next cycle; the next grant is visible 1 cycle later.
- With `FEED_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8: feed 2 stalls after its first byte for 8 cycles:
  - One-cycle `abort_out` and `parser_reset_out`.
  - Remaining bytes through last are flushed.
  - msg_count unchanged.
  - The next grant goes to feed 3.
- Reset asserted mid-STREAM → next cycle grant_out=0, busy_out=0, msg_count=0; RR restarts at feed 0.

Source files
------------

// File: rtl/parser_pkg.sv
// Shared types and constants for feed_arbiter.
// The ABORT/FLUSH states exist only when FEED_TIMEOUT_EN is defined.
package parser_pkg;

    localparam int MSG_COUNT_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STREAM    = 3'd1,
        WAIT_DONE = 3'd2
`ifdef FEED_TIMEOUT_EN
        ,
        ABORT     = 3'd3,
        FLUSH     = 3'd4
`endif
    } feed_arb_state_t;

endpackage

// File: rtl/feed_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_FEEDS = 4
) (
    input  logic [NUM_FEEDS-1:0]         req,
    input  logic [$clog2(NUM_FEEDS)-1:0] ptr,
    output logic [NUM_FEEDS-1:0]         grant,
    output logic [$clog2(NUM_FEEDS)-1:0] id
);

    localparam int ID_W = $clog2(NUM_FEEDS);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_FEEDS; i++) begin
            idx = (int'(ptr) + i) % NUM_FEEDS;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                id         = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/feed_arbiter.sv
// Round-robin, message-granular arbiter sharing one parser byte port among NUM_FEEDS feeds.
// Define FEED_TIMEOUT_EN to add the mid-message stall timeout with ABORT/FLUSH recovery.
module feed_arbiter
    import parser_pkg::*;
#(
    parameter int NUM_FEEDS      = 4,
    parameter int DATA_WIDTH     = 7,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                               clk_in,
    input  logic                               reset_in,
    input  logic [NUM_FEEDS*(DATA_WIDTH+1)-1:0] feed_data_in,
    input  logic [NUM_FEEDS-1:0]               feed_valid_in,
    input  logic [NUM_FEEDS-1:0]               feed_last_in,
    output logic [NUM_FEEDS-1:0]               feed_ready_out,
    output logic [DATA_WIDTH:0]                parser_data_out,
    output logic                               parser_valid_out,
    input  logic                               parser_ready_in,
    input  logic                               parser_done_in,
    output logic [NUM_FEEDS-1:0]               grant_out,
    output logic [$clog2(NUM_FEEDS)-1:0]       grant_id_out,
    output logic                               busy_out,
    output logic [MSG_COUNT_W-1:0]             msg_count_out,
    output logic                               abort_out,
    output logic                               parser_reset_out
);

    localparam int ID_W   = $clog2(NUM_FEEDS);
    localparam int BYTE_W = DATA_WIDTH + 1;

    if (NUM_FEEDS < 2 || NUM_FEEDS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("feed_arbiter: parameter out of range");
    end

    feed_arb_state_t      state;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      next_ptr;
    logic [ID_W-1:0]      arb_id;
    logic [NUM_FEEDS-1:0] arb_grant;
    logic [BYTE_W-1:0]    sel_data;
    logic                 sel_valid;
    logic                 sel_last;
    logic                 xfer;
    logic                 complete;

    rr_arbiter #(.NUM_FEEDS(NUM_FEEDS)) u_rr (
        .req   (feed_valid_in),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .id    (arb_id)
    );

    // Select the granted feed's lanes; in IDLE this still tracks the last owner.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_FEEDS; i++) begin
            if (grant_id_out == ID_W'(i)) begin
                sel_data  = feed_data_in[i*BYTE_W +: BYTE_W];
                sel_valid = feed_valid_in[i];
                sel_last  = feed_last_in[i];
            end
        end
    end

    assign next_ptr = (grant_id_out == ID_W'(NUM_FEEDS - 1)) ? '0 : grant_id_out + 1'b1;
    assign xfer     = (state == STREAM) && sel_valid && parser_ready_in;
    assign complete = parser_done_in &&
                      ((xfer && sel_last) || (state == WAIT_DONE));
    assign busy_out = (state != IDLE);

    always_comb begin
        parser_data_out  = '0;
        parser_valid_out = 1'b0;
        feed_ready_out   = '0;
        if (state == STREAM) begin
            parser_data_out  = sel_data;
            parser_valid_out = sel_valid;
            feed_ready_out   = grant_out & {NUM_FEEDS{parser_ready_in}};
        end
`ifdef FEED_TIMEOUT_EN
        if (state == FLUSH) begin
            feed_ready_out = grant_out;
        end
`endif
    end

`ifdef FEED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer;
    logic          moved;
    logic          stall_expired;

    assign moved = xfer || ((state == FLUSH) && sel_valid);
    assign stall_expired = ((state == STREAM) || (state == WAIT_DONE) || (state == FLUSH)) &&
                           !moved && !complete && (timer == TW'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter; the abort pulse is only raised when leaving a live message.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            timer            <= '0;
            abort_out        <= 1'b0;
            parser_reset_out <= 1'b0;
        end else begin
            abort_out        <= stall_expired && (state != FLUSH);
            parser_reset_out <= stall_expired && (state != FLUSH);
            if ((state == IDLE) || (state == ABORT) || moved) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end
`else
    assign abort_out        = 1'b0;
    assign parser_reset_out = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant_out     <= '0;
            grant_id_out  <= '0;
            msg_count_out <= '0;
        end else if (complete) begin
            state         <= IDLE;
            rr_ptr        <= next_ptr;
            grant_out     <= '0;
            msg_count_out <= msg_count_out + 1'b1;
`ifdef FEED_TIMEOUT_EN
        end else if (stall_expired) begin
            if (state == FLUSH) begin
                state     <= IDLE;
                grant_out <= '0;
            end else begin
                state  <= ABORT;
                rr_ptr <= next_ptr;
            end
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|feed_valid_in) begin
                        state        <= STREAM;
                        grant_out    <= arb_grant;
                        grant_id_out <= arb_id;
                    end
                end
                STREAM: begin
                    if (xfer && sel_last) begin
                        state <= WAIT_DONE;
                    end
                end
`ifdef FEED_TIMEOUT_EN
                ABORT: state <= FLUSH;
                FLUSH: begin
                    if (sel_valid && sel_last) begin
                        state     <= IDLE;
                        grant_out <= '0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
